// File: rtl/arb_request_unit_pkg.sv
// Shared flit-type codes, FSM state encodings and helpers for the arbiter
// request unit.
package arb_request_unit_pkg;

  // Type field occupies the top TYPE_W bits of every flit.
  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEAD   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  function automatic logic is_packet_start(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/arb_request_unit_flit_fifo.sv
// Synchronous flit FIFO with registered occupancy; DEPTH must be a power of 2
// so the pointers wrap naturally.
module flit_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [FLIT_W-1:0]      push_flit,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output logic [FLIT_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; occupancy alone decides validity,
  // which keeps the array a plain RAM with no reset fan-out.
  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_flit;
  end

endmodule

// File: rtl/arb_request_unit.sv
// Requester side of the matrix arbiter: buffers flits, requests, holds lock
// across wormhole packets, forwards under credits. Optional ARB_STARVE_EN.
module arb_request_unit
  import arb_request_unit_pkg::*;
#(
  parameter int FLIT_W     = 32,
  parameter int DEPTH      = 4,
  parameter int CREDITS    = 4,
  parameter int STARVE_LIM = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic              req,
  output logic              lock,
  input  logic              gnt,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              credit_in,
  output logic              starve
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CRD_W = $clog2(CREDITS + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CREDITS < 1 || STARVE_LIM < 1) begin : g_bad_cfg
    $error("arb_request_unit: illegal parameterisation");
  end

  logic              fifo_full, fifo_empty;
  logic [FLIT_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count, count_next;
  flit_type_e        head_type;
  logic              push_acc, take, drop, pop, can_send;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              lock_q, lock_d;
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic              proto_err_q, proto_err_d;

  flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (in_valid),
    .push_flit (in_flit),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign head_type = flit_type_e'(fifo_head[FLIT_W-1 -: TYPE_W]);
  assign in_ready  = !fifo_full;

  // NOTE: every output of this block gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    out_flit_d  = out_flit_q;
    credits_d   = credits_q;
    proto_err_d = proto_err_q;
    drop        = 1'b0;

    can_send = !fifo_empty && (credits_q != '0);
    take     = gnt && req_q && can_send;
    push_acc = in_valid && !fifo_full;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_packet_start(head_type)) begin
            state_d = ST_REQ;
          end else begin
            // A body/tail with no packet open is orphaned: discard it.
            drop        = 1'b1;
            proto_err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (take) state_d = (head_type == FLIT_HEAD) ? ST_XFER : ST_IDLE;
      end
      ST_XFER: begin
        if (take && head_type == FLIT_TAIL) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      out_valid_d = 1'b1;
      out_flit_d  = fifo_head;
    end

    unique case ({take, credit_in})
      2'b10:   credits_d = credits_q - CRD_W'(1);
      2'b01:   if (credits_q != CRD_W'(CREDITS)) credits_d = credits_q + CRD_W'(1);
      default: credits_d = credits_q;
    endcase

    pop        = take || drop;
    count_next = fifo_count + CNT_W'(push_acc) - CNT_W'(pop);

    // Request and lock are registered from next-cycle values so they equal
    // the decode of the state they are presented alongside.
    req_d  = (state_d != ST_IDLE) && (count_next != '0) && (credits_d != '0);
    lock_d = (state_d == ST_XFER);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      lock_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      credits_q   <= CRD_W'(CREDITS);
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      lock_q      <= lock_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      credits_q   <= credits_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign req       = req_q;
  assign lock      = lock_q;
  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;

`ifdef ARB_STARVE_EN
  localparam int STV_W = $clog2(STARVE_LIM + 1);

  logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starve_q, starve_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!req_q || gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STV_W'(STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + STV_W'(1);
    end
    starve_d = starve_q || (starve_cnt_d == STV_W'(STARVE_LIM));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign starve = starve_q;
`else
  assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_arb_request_unit.sv
// Directed bench for arb_request_unit: u_dut has 4 credits, u_dut2 has 2
// credits for the stall scenario; both share stimulus.
module tb_arb_request_unit;
  import arb_request_unit_pkg::*;

  localparam logic [31:0] F_HEAD   = 32'h8000_0001;
  localparam logic [31:0] F_BODY1  = 32'h0000_0002;
  localparam logic [31:0] F_BODY2  = 32'h0000_0003;
  localparam logic [31:0] F_TAIL   = 32'h4000_0004;
  localparam logic [31:0] F_SINGLE = 32'hC000_0005;

`ifdef ARB_STARVE_EN
  localparam logic STARVE_ON = 1'b1;
`else
  localparam logic STARVE_ON = 1'b0;
`endif

  logic        CLK, RST;
  logic        in_valid, gnt, credit_in;
  logic [31:0] in_flit;
  logic        in_ready, req, lock, out_valid, starve;
  logic [31:0] out_flit;
  logic        in_ready_2, req_2, lock_2, out_valid_2, starve_2;
  logic [31:0] out_flit_2;

  int tests = 0;
  int fails = 0;

  arb_request_unit #(.FLIT_W(32), .DEPTH(4), .CREDITS(4), .STARVE_LIM(8)) u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .req(req), .lock(lock), .gnt(gnt), .out_valid(out_valid), .out_flit(out_flit),
    .credit_in(credit_in), .starve(starve)
  );

  arb_request_unit #(.FLIT_W(32), .DEPTH(4), .CREDITS(2), .STARVE_LIM(8)) u_dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready_2),
    .req(req_2), .lock(lock_2), .gnt(gnt), .out_valid(out_valid_2), .out_flit(out_flit_2),
    .credit_in(credit_in), .starve(starve_2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; in_valid = 1'b0; in_flit = '0; gnt = 1'b0; credit_in = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    tests++; if (u_dut.credits_q !== 3'd4) begin fails++; $display("FAIL reset_credit_sat: got %0d want 4", u_dut.credits_q); end
    tests++; if ({req, lock, out_valid, in_ready} !== 4'b0001) begin fails++; $display("FAIL reset_idle_outputs: got %b want 0001", {req, lock, out_valid, in_ready}); end
    in_valid = 1'b1; in_flit = F_HEAD;
    tick();
    in_flit = F_BODY1;
    tick();
    in_valid = 1'b0;
    tests++; if (req !== 1'b1) begin fails++; $display("FAIL reset_pre_req: got %b want 1", req); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tests++; if ({lock, out_valid} !== 2'b11) begin fails++; $display("FAIL reset_pre_lock: got %b want 11", {lock, out_valid}); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tests++; if ({req, lock, out_valid, in_ready} !== 4'b0001) begin fails++; $display("FAIL reset_mid_packet: got %b want 0001", {req, lock, out_valid, in_ready}); end
    tests++; if (u_dut.credits_q !== 3'd4) begin fails++; $display("FAIL reset_credits: got %0d want 4", u_dut.credits_q); end
    tests++; if (out_flit !== 32'h0) begin fails++; $display("FAIL reset_out_flit: got %h want 0", out_flit); end
    tests++; if (u_dut.fifo_count !== 3'd0 || u_dut.state_q !== ST_IDLE) begin fails++; $display("FAIL reset_fifo_state: got count %0d state %0d want 0 0", u_dut.fifo_count, u_dut.state_q); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_flit = F_SINGLE;
    tick();
    in_valid = 1'b0;
    tests++; if (req !== 1'b0) begin fails++; $display("FAIL single_req_early: got %b want 0", req); end
    tick();
    tests++; if ({req, lock} !== 2'b10) begin fails++; $display("FAIL single_req: got %b want 10", {req, lock}); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_flit !== F_SINGLE) begin fails++; $display("FAIL single_out: got %b/%h want 1/%h", out_valid, out_flit, F_SINGLE); end
    tests++; if (lock !== 1'b0 || u_dut.state_q !== ST_IDLE) begin fails++; $display("FAIL single_idle: got lock %b state %0d want 0 0", lock, u_dut.state_q); end
    tick();
    tests++; if ({out_valid, req, lock} !== 3'b000) begin fails++; $display("FAIL single_one_pulse: got %b want 000", {out_valid, req, lock}); end
  endtask

  task automatic test_packet();
    logic [31:0] pkt [3];
    pkt[0] = F_HEAD; pkt[1] = F_BODY1; pkt[2] = F_TAIL;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_flit = pkt[i];
      tick();
    end
    in_valid = 1'b0;
    tests++; if ({req, lock} !== 2'b10) begin fails++; $display("FAIL packet_pre_grant: got %b want 10", {req, lock}); end
    gnt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || out_flit !== pkt[i]) begin fails++; $display("FAIL packet_flit%0d: got %b/%h want 1/%h", i, out_valid, out_flit, pkt[i]); end
      tests++; if (lock !== (i < 2)) begin fails++; $display("FAIL packet_lock%0d: got %b want %b", i, lock, (i < 2)); end
    end
    gnt = 1'b0;
    tick();
    tests++; if ({out_valid, req, lock} !== 3'b000 || u_dut.credits_q !== 3'd1) begin fails++; $display("FAIL packet_end: got %b credits %0d want 000 credits 1", {out_valid, req, lock}, u_dut.credits_q); end
  endtask

  task automatic test_credit_stall();
    logic [31:0] pkt [4];
    pkt[0] = F_HEAD; pkt[1] = F_BODY1; pkt[2] = F_BODY2; pkt[3] = F_TAIL;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_flit = pkt[i];
      tick();
    end
    in_valid = 1'b0;
    gnt = 1'b1;
    tick();
    tests++; if (out_flit_2 !== F_HEAD || {req_2, lock_2} !== 2'b11) begin fails++; $display("FAIL stall_flit0: got %h %b want %h 11", out_flit_2, {req_2, lock_2}, F_HEAD); end
    tick();
    tests++; if (out_flit_2 !== F_BODY1 || {req_2, lock_2} !== 2'b01) begin fails++; $display("FAIL stall_no_credit: got %h %b want %h 01", out_flit_2, {req_2, lock_2}, F_BODY1); end
    tick();
    tests++; if (out_valid_2 !== 1'b0 || u_dut2.fifo_count !== 3'd2) begin fails++; $display("FAIL stall_stray_gnt: got valid %b count %0d want 0 2", out_valid_2, u_dut2.fifo_count); end
    gnt = 1'b0; credit_in = 1'b1;
    tick();
    tests++; if ({req_2, lock_2} !== 2'b11) begin fails++; $display("FAIL stall_credit_return: got %b want 11", {req_2, lock_2}); end
    credit_in = 1'b0; gnt = 1'b1;
    tick();
    tests++; if (out_valid_2 !== 1'b1 || out_flit_2 !== F_BODY2 || req_2 !== 1'b0) begin fails++; $display("FAIL stall_flit2: got %b/%h req %b want 1/%h req 0", out_valid_2, out_flit_2, req_2, F_BODY2); end
    gnt = 1'b0; credit_in = 1'b1;
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0; credit_in = 1'b0;
    tests++; if (out_flit_2 !== F_TAIL || lock_2 !== 1'b0 || u_dut2.credits_q !== 2'd1) begin fails++; $display("FAIL stall_tail_net_credit: got %h lock %b credits %0d want %h 0 1", out_flit_2, lock_2, u_dut2.credits_q, F_TAIL); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    gnt = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0 || u_dut.credits_q !== 3'd4) begin fails++; $display("FAIL full_stray_empty: got %b credits %0d want 0 4", out_valid, u_dut.credits_q); end
    in_valid = 1'b1; in_flit = F_HEAD;
    tick();
    gnt = 1'b0;
    tests++; if (u_dut.fifo_count !== 3'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL full_stray_push: got count %0d valid %b want 1 0", u_dut.fifo_count, out_valid); end
    for (int i = 1; i <= 4; i++) begin
      in_flit = 32'h0000_0010 + 32'(i);
      tick();
      if (i == 3) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
      end
    end
    in_valid = 1'b0;
    tests++; if (u_dut.fifo_count !== 3'd4) begin fails++; $display("FAIL full_fifth_rejected: got %0d want 4", u_dut.fifo_count); end
    gnt = 1'b1;
    tick();
    tests++; if (out_flit !== F_HEAD || in_ready !== 1'b1) begin fails++; $display("FAIL full_drain_head: got %h ready %b want %h 1", out_flit, in_ready, F_HEAD); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      tests++; if (out_flit !== 32'h0000_0010 + 32'(i)) begin fails++; $display("FAIL full_drain%0d: got %h want %h", i, out_flit, 32'h0000_0010 + 32'(i)); end
    end
    gnt = 1'b0;
    tests++; if ({req, lock} !== 2'b01) begin fails++; $display("FAIL full_empty_stall: got %b want 01", {req, lock}); end
  endtask

  task automatic test_drop();
    do_reset();
    in_valid = 1'b1; in_flit = F_BODY1;
    tick();
    in_valid = 1'b0;
    tick();
    tests++; if (u_dut.fifo_count !== 3'd0 || u_dut.proto_err_q !== 1'b1 || {req, out_valid} !== 2'b00) begin fails++; $display("FAIL drop_orphan: got count %0d err %b %b want 0 1 00", u_dut.fifo_count, u_dut.proto_err_q, {req, out_valid}); end
  endtask

  task automatic test_starve();
    do_reset();
    in_valid = 1'b1; in_flit = F_HEAD;
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        tests++; if (starve !== 1'b0) begin fails++; $display("FAIL starve_early: got %b want 0", starve); end
      end
    end
    tests++; if (starve !== STARVE_ON) begin fails++; $display("FAIL starve_at_limit: got %b want %b", starve, STARVE_ON); end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    tests++; if (starve !== STARVE_ON || out_valid !== 1'b0) begin fails++; $display("FAIL starve_sticky: got %b valid %b want %b 0", starve, out_valid, STARVE_ON); end
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_flit = '0; gnt = 1'b0; credit_in = 1'b0;
    tick();
    test_reset();
    test_single();
    test_packet();
    test_credit_stall();
    test_fifo_full();
    test_drop();
    test_starve();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
